top2_frame_ctrl: RTL and testbench



---
 rtl/top2_pkg.sv | 10 +
 rtl/top2_tracker.sv | 32 +++
 rtl/top2_frame_ctrl.sv | 99 +++++++++
 tb/tb_top2_frame_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/top2_pkg.sv
// Shared types for the per-frame top-2 peak controller.
package top2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/top2_tracker.sv
// Tracks largest and second-largest distinct unsigned values; result visible the cycle after upd.
// No backpressure: the caller gates upd; clr wins over a same-cycle upd.
module top2_tracker #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  upd,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] largest,
    output logic [DATA_WIDTH-1:0] second
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            largest <= '0;
            second  <= '0;
        end else if (clr) begin
            largest <= '0;
            second  <= '0;
        end else if (upd) begin
            if (din > largest) begin
                largest <= din;
                second  <= largest;
            end else if ((din > second) && (din < largest)) begin
                second <= din;
            end
        end
    end

endmodule

// File: rtl/top2_frame_ctrl.sv
// Frames cfg_len samples and reports their top-2 values; result valid the cycle after the last accept.
// in_ready only while collecting; result held until out_ready, back-to-back start allowed on the handshake.
module top2_frame_ctrl
    import top2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  abort,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_largest,
    output logic [DATA_WIDTH-1:0] out_second
);

    state_t               state;
    state_t               state_nx;
    logic [LEN_WIDTH-1:0] count;
    logic [LEN_WIDTH-1:0] len;
    logic                 start_ok;
    logic                 accept;
    logic                 last;
    logic                 clr;
    logic                 upd;

    assign start_ok = start && (cfg_len != '0);
    assign accept   = in_valid && (state == RUN);
    assign last     = (count == len - LEN_WIDTH'(1));
    // A new frame opens from IDLE, or straight out of HOLD when the result is taken.
    assign clr      = start_ok && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign upd      = accept && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_ok) state_nx = RUN;
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (accept && last) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = start_ok ? RUN : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN) || (state == HOLD);
        in_ready  = (state == RUN);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            len   <= '0;
        end else if (clr) begin
            count <= '0;
            len   <= cfg_len;
        end else if (upd) begin
            count <= count + LEN_WIDTH'(1);
        end
    end

    top2_tracker #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_tracker (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .upd     (upd),
        .din     (din),
        .largest (out_largest),
        .second  (out_second)
    );

endmodule

// File: tb/tb_top2_frame_ctrl.sv
// Directed bench for top2_frame_ctrl with a frame-level reference model checked every cycle.
module tb_top2_frame_ctrl;

    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic          abort = 1'b0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] din = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_largest;
    logic [DW-1:0] out_second;

    int checks = 0;
    int errors = 0;

    top2_frame_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_len     (cfg_len),
        .abort       (abort),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din         (din),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_largest (out_largest),
        .out_second  (out_second)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame phase plus the list of samples taken in the current frame.
    int            m_phase = 0;   // 0 idle, 1 collecting, 2 result pending
    int            m_len = 0;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_L = '0;
    logic [DW-1:0] m_S = '0;
    bit            m_known = 1'b1;

    function automatic void top2_of(input logic [DW-1:0] q[$], output logic [DW-1:0] l,
                                    output logic [DW-1:0] s);
        l = '0;
        s = '0;
        foreach (q[i]) if (q[i] > l) l = q[i];
        foreach (q[i]) if (q[i] < l && q[i] > s) s = q[i];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_len   = 0;
            m_q.delete();
            m_L     = '0;
            m_S     = '0;
            m_known = 1'b1;
        end else begin
            case (m_phase)
                0: if (start && cfg_len != 0) begin
                    m_phase = 1; m_len = int'(cfg_len); m_q.delete(); m_known = 1'b0;
                end
                1: if (abort) begin
                    m_phase = 0;
                end else if (in_valid) begin
                    m_q.push_back(din);
                    if (m_q.size() == m_len) begin
                        m_phase = 2;
                        top2_of(m_q, m_L, m_S);
                        m_known = 1'b1;
                    end
                end
                default: if (out_ready) begin
                    m_known = 1'b0;
                    if (start && cfg_len != 0) begin
                        m_phase = 1; m_len = int'(cfg_len); m_q.delete();
                    end else begin
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    always begin
        @(posedge clk);
        #1;
        chk("busy", 64'(busy), 64'(m_phase != 0));
        chk("in_ready", 64'(in_ready), 64'(m_phase == 1));
        chk("out_valid", 64'(out_valid), 64'(m_phase == 2));
        if (m_known) begin
            chk("out_largest", 64'(out_largest), 64'(m_L));
            chk("out_second", 64'(out_second), 64'(m_S));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input int len);
        start = 1'b1; cfg_len = LW'(len);
        tick();
        start = 1'b0; cfg_len = '0;
    endtask

    task automatic send(input logic [DW-1:0] d, input int gap);
        in_valid = 1'b1; din = d;
        tick();
        in_valid = 1'b0; din = '0;
        repeat (gap) tick();
    endtask

    task automatic wait_ov();
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        chk("out_valid_wait", 64'(out_valid), 64'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic pin(input string name, input logic [DW-1:0] l, input logic [DW-1:0] s);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_largest"}, 64'(out_largest), 64'(l));
        chk({name, "_second"}, 64'(out_second), 64'(s));
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_largest", 64'(out_largest), 64'd0);

        // Reset in the middle of a frame, then a fresh frame.
        do_start(4);
        send(32'd1, 0); send(32'd2, 0); send(32'd3, 0);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_largest", 64'(out_largest), 64'd0);
        chk("midrst_second", 64'(out_second), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        do_start(2);
        send(32'd5, 0); send(32'd9, 0);
        wait_ov();
        pin("f59", 32'd9, 32'd5);
        take();

        // Result appears the cycle after the last accept and holds under backpressure.
        do_start(5);
        send(32'd3, 0); send(32'd7, 0); send(32'd7, 0); send(32'd2, 0); send(32'd5, 0);
        chk("latency_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            abort = (i == 1);
            tick();
            pin("hold", 32'd7, 32'd5);
        end
        abort = 1'b0;
        take();

        do_start(4);
        repeat (4) send(32'd10, 0);
        wait_ov();
        pin("dup", 32'd10, 32'd0);
        take();
        do_start(1);
        send(32'hFFFF_FFFF, 0);
        wait_ov();
        pin("max1", 32'hFFFF_FFFF, 32'd0);
        take();

        // Gaps in in_valid must not advance the frame.
        do_start(3);
        send(32'd1, 2); send(32'd4, 1); send(32'd2, 0);
        wait_ov();
        pin("gaps", 32'd4, 32'd2);
        take();

        // Abort, with a sample offered on the same cycle, drops the frame.
        do_start(4);
        send(32'd20, 0); send(32'd30, 0);
        abort = 1'b1; in_valid = 1'b1; din = 32'd99;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("abort_no_valid", 64'(out_valid), 64'd0);
        start = 1'b1; cfg_len = '0;
        tick();
        start = 1'b0;
        chk("len0_busy", 64'(busy), 64'd0);

        // Back-to-back frame started on the handshake cycle.
        do_start(3);
        send(32'd100, 0); send(32'd50, 0); send(32'd75, 0);
        wait_ov();
        pin("pre_b2b", 32'd100, 32'd75);
        out_ready = 1'b1; start = 1'b1; cfg_len = 8'd2;
        tick();
        out_ready = 1'b0; start = 1'b0; cfg_len = '0;
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        chk("b2b_out_valid", 64'(out_valid), 64'd0);
        send(32'd6, 0); send(32'd8, 0);
        wait_ov();
        pin("b2b", 32'd8, 32'd6);
        take();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
